// File: rtl/uart_echo_fifo.sv
// ---------------------------------------------------------------------------
// uart_echo_fifo
//
// Parametrised UART transceiver that receives serial frames on RxD, buffers
// every correctly received word in a receive-to-transmit FIFO, and replays
// the buffered words on TxD whenever transmit is enabled. The last good word,
// pulse/sticky status flags and the FIFO occupancy are exposed to the
// surrounding logic.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (minimum 4)
//   DATA_BITS     data bits per frame (5..9)
//   FIFO_DEPTH    FIFO entries (power of two, minimum 2)
//
// Ports:
//   clk         single clock, all state on the rising edge
//   reset_n     asynchronous active-low reset
//   RxD         serial input, idle high, asynchronous to clk
//   rx_enable   1 = receiver runs, 0 = receiver held idle (frame aborted)
//   tx_enable   1 = transmitter may start a new frame
//   TxD         serial output, idle high
//   data        last correctly received word
//   rx_valid    one-cycle pulse when data updates
//   tx_busy     high while a frame is on TxD
//   fifo_count  current FIFO occupancy
//   overrun     sticky: a good word was dropped because the FIFO was full
//   frame_err   one-cycle pulse: stop bit sampled low
//   parity_err  one-cycle pulse: parity mismatch
//
// Build option:
//   UART_PARITY_EN  when defined, one even-parity bit follows the data bits
//                   in both directions and parity_err is driven; when not
//                   defined, frames are start+data+stop and parity_err is 0.
// ---------------------------------------------------------------------------
module uart_echo_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          RxD,
  input  logic                          rx_enable,
  input  logic                          tx_enable,
  output logic                          TxD,
  output logic [DATA_BITS-1:0]          data,
  output logic                          rx_valid,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          parity_err
);

  localparam int ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int COUNT_W = ADDR_W + 1;
  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int BIT_W   = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0]   BIT_END    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   HALF_END   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(DATA_BITS - 1);
  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(FIFO_DEPTH);

  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_STOP   = 3'd4;
  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_STOP   = 3'd4;
`ifdef UART_PARITY_EN
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] TX_PARITY = 3'd3;
`endif

  // Input synchroniser plus one extra stage used only for edge detection.
  logic rxSync1_q, rxSync2_q, rxPrev_q;
  logic rxFall;

  // Receiver state.
  logic [2:0]           rxState_q, rxState_d;
  logic [CNT_W-1:0]     rxCnt_q, rxCnt_d;
  logic [BIT_W-1:0]     rxBitIdx_q, rxBitIdx_d;
  logic [DATA_BITS-1:0] rxShift_q, rxShift_d;
  logic                 rxStopSample;
  logic                 frameErrNow;
  logic                 goodWord;
`ifdef UART_PARITY_EN
  logic                 rxParity_q, rxParity_d;
  logic                 parityErrNow;
  logic                 parityErr_q;
`endif

  // Status registers.
  logic [DATA_BITS-1:0] data_q;
  logic                 rxValid_q;
  logic                 frameErr_q;
  logic                 overrun_q;

  // FIFO.
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]    wrPtr_q, rdPtr_q;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [DATA_BITS-1:0] fifoHead;
  logic                 push, pop;

  // Transmitter state.
  logic [2:0]           txState_q, txState_d;
  logic [CNT_W-1:0]     txCnt_q, txCnt_d;
  logic [BIT_W-1:0]     txBitIdx_q, txBitIdx_d;
  logic [DATA_BITS-1:0] txShift_q, txShift_d;
  logic                 txBit;
  logic                 txd_q;
  logic                 txBusy_q;
`ifdef UART_PARITY_EN
  logic                 txParity_q, txParity_d;
`endif

  // RxD is asynchronous, so it is brought into the clock domain through two
  // flops. All stages reset to the idle line level so that leaving reset
  // never looks like a start-bit edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxSync1_q <= 1'b1;
      rxSync2_q <= 1'b1;
      rxPrev_q  <= 1'b1;
    end else begin
      rxSync1_q <= RxD;
      rxSync2_q <= rxSync1_q;
      rxPrev_q  <= rxSync2_q;
    end
  end

  // Only a high-to-low transition starts a frame; a line that stays low
  // after a bad stop bit must not be mistaken for a new start bit.
  assign rxFall = rxPrev_q & ~rxSync2_q;

  // Receiver next-state logic. The start bit is checked half a bit in, so
  // every later sample lands near the middle of its bit.
  always_comb begin
    rxState_d    = rxState_q;
    rxCnt_d      = rxCnt_q;
    rxBitIdx_d   = rxBitIdx_q;
    rxShift_d    = rxShift_q;
`ifdef UART_PARITY_EN
    rxParity_d   = rxParity_q;
`endif
    rxStopSample = 1'b0;
    if (!rx_enable) begin
      rxState_d  = RX_IDLE;
      rxCnt_d    = '0;
      rxBitIdx_d = '0;
    end else begin
      case (rxState_q)
        RX_IDLE: begin
          if (rxFall) begin
            rxState_d = RX_START;
            rxCnt_d   = '0;
          end
        end
        RX_START: begin
          if (rxCnt_q == HALF_END) begin
            rxCnt_d    = '0;
            rxBitIdx_d = '0;
            rxState_d  = rxSync2_q ? RX_IDLE : RX_DATA;
          end else begin
            rxCnt_d = rxCnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rxCnt_q == BIT_END) begin
            rxCnt_d   = '0;
            rxShift_d = {rxSync2_q, rxShift_q[DATA_BITS-1:1]};
            if (rxBitIdx_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
              rxState_d = RX_PARITY;
`else
              rxState_d = RX_STOP;
`endif
            end else begin
              rxBitIdx_d = rxBitIdx_q + 1'b1;
            end
          end else begin
            rxCnt_d = rxCnt_q + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (rxCnt_q == BIT_END) begin
            rxCnt_d    = '0;
            rxParity_d = rxSync2_q;
            rxState_d  = RX_STOP;
          end else begin
            rxCnt_d = rxCnt_q + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (rxCnt_q == BIT_END) begin
            rxCnt_d      = '0;
            rxStopSample = 1'b1;
            rxState_d    = RX_IDLE;
          end else begin
            rxCnt_d = rxCnt_q + 1'b1;
          end
        end
        default: begin
          rxState_d = RX_IDLE;
          rxCnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxState_q  <= RX_IDLE;
      rxCnt_q    <= '0;
      rxBitIdx_q <= '0;
      rxShift_q  <= '0;
`ifdef UART_PARITY_EN
      rxParity_q <= 1'b0;
`endif
    end else begin
      rxState_q  <= rxState_d;
      rxCnt_q    <= rxCnt_d;
      rxBitIdx_q <= rxBitIdx_d;
      rxShift_q  <= rxShift_d;
`ifdef UART_PARITY_EN
      rxParity_q <= rxParity_d;
`endif
    end
  end

  // Frame classification at the stop-bit sample. Either error discards the
  // word; both errors may pulse together.
  assign frameErrNow = rxStopSample & ~rxSync2_q;
`ifdef UART_PARITY_EN
  assign parityErrNow = rxStopSample & (rxParity_q ^ (^rxShift_q));
  assign goodWord     = rxStopSample & rxSync2_q & ~parityErrNow;
`else
  assign goodWord     = rxStopSample & rxSync2_q;
`endif

  // A pop only happens when the FIFO was non-empty at the previous edge, so
  // a push into an empty FIFO is never popped in the same cycle. A pop frees
  // a slot in the same cycle, so a push at full still succeeds alongside it.
  assign pop      = (txState_q == TX_IDLE) && tx_enable && (count_q != '0);
  assign push     = goodWord && ((count_q != FULL_COUNT) || pop);
  assign fifoHead = mem_q[rdPtr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= rxShift_q;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Status outputs. Overrun is sticky while the receiver runs and is cleared
  // by holding the receiver disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q      <= '0;
      rxValid_q   <= 1'b0;
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
      parityErr_q <= 1'b0;
`endif
    end else begin
      rxValid_q   <= goodWord;
      frameErr_q  <= frameErrNow;
`ifdef UART_PARITY_EN
      parityErr_q <= parityErrNow;
`endif
      if (goodWord) begin
        data_q <= rxShift_q;
      end
      if (!rx_enable) begin
        overrun_q <= 1'b0;
      end else if (goodWord && !push) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Transmitter next-state logic. A new frame is only started from IDLE, so
  // dropping tx_enable lets the current frame finish.
  always_comb begin
    txState_d  = txState_q;
    txCnt_d    = txCnt_q;
    txBitIdx_d = txBitIdx_q;
    txShift_d  = txShift_q;
`ifdef UART_PARITY_EN
    txParity_d = txParity_q;
`endif
    case (txState_q)
      TX_IDLE: begin
        if (pop) begin
          txState_d  = TX_START;
          txCnt_d    = '0;
          txBitIdx_d = '0;
          txShift_d  = fifoHead;
`ifdef UART_PARITY_EN
          txParity_d = ^fifoHead;
`endif
        end
      end
      TX_START: begin
        if (txCnt_q == BIT_END) begin
          txCnt_d   = '0;
          txState_d = TX_DATA;
        end else begin
          txCnt_d = txCnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (txCnt_q == BIT_END) begin
          txCnt_d   = '0;
          txShift_d = txShift_q >> 1;
          if (txBitIdx_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            txState_d = TX_PARITY;
`else
            txState_d = TX_STOP;
`endif
          end else begin
            txBitIdx_d = txBitIdx_q + 1'b1;
          end
        end else begin
          txCnt_d = txCnt_q + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (txCnt_q == BIT_END) begin
          txCnt_d   = '0;
          txState_d = TX_STOP;
        end else begin
          txCnt_d = txCnt_q + 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (txCnt_q == BIT_END) begin
          txCnt_d   = '0;
          txState_d = TX_IDLE;
        end else begin
          txCnt_d = txCnt_q + 1'b1;
        end
      end
      default: begin
        txState_d = TX_IDLE;
        txCnt_d   = '0;
      end
    endcase
  end

  // Line level implied by the current transmitter state.
  always_comb begin
    txBit = 1'b1;
    case (txState_q)
      TX_START:  txBit = 1'b0;
      TX_DATA:   txBit = txShift_q[0];
`ifdef UART_PARITY_EN
      TX_PARITY: txBit = txParity_q;
`endif
      default:   txBit = 1'b1;
    endcase
  end

  // TxD and tx_busy are registered one cycle behind the state, giving a
  // glitch-free output and the pop -> start-bit latency of one extra cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txState_q  <= TX_IDLE;
      txCnt_q    <= '0;
      txBitIdx_q <= '0;
      txShift_q  <= '0;
`ifdef UART_PARITY_EN
      txParity_q <= 1'b0;
`endif
      txd_q      <= 1'b1;
      txBusy_q   <= 1'b0;
    end else begin
      txState_q  <= txState_d;
      txCnt_q    <= txCnt_d;
      txBitIdx_q <= txBitIdx_d;
      txShift_q  <= txShift_d;
`ifdef UART_PARITY_EN
      txParity_q <= txParity_d;
`endif
      txd_q      <= txBit;
      txBusy_q   <= (txState_q != TX_IDLE);
    end
  end

  assign TxD        = txd_q;
  assign tx_busy    = txBusy_q;
  assign data       = data_q;
  assign rx_valid   = rxValid_q;
  assign fifo_count = count_q;
  assign overrun    = overrun_q;
  assign frame_err  = frameErr_q;
`ifdef UART_PARITY_EN
  assign parity_err = parityErr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_echo_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_echo_fifo
//
// Directed bench for uart_echo_fifo with CLKS_PER_BIT = 16 and a 16-entry
// FIFO. Single-frame receive cases come from a vector table; latency,
// glitch rejection, overrun, reset-during-transmit and parity are
// hand-written sequences. Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_echo_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 16;
`ifdef UART_PARITY_EN
  localparam int DB = 7;
  localparam int PB = 1;
`else
  localparam int DB = 8;
  localparam int PB = 0;
`endif
  localparam int FRAME_LEN = (2 + DB + PB) * CPB;

  logic                       clk;
  logic                       reset_n;
  logic                       RxD;
  logic                       rx_enable;
  logic                       tx_enable;
  logic                       TxD;
  logic [DB-1:0]              data;
  logic                       rx_valid;
  logic                       tx_busy;
  logic [$clog2(DEPTH):0]     fifo_count;
  logic                       overrun;
  logic                       frame_err;
  logic                       parity_err;

  uart_echo_fifo #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .RxD        (RxD),
    .rx_enable  (rx_enable),
    .tx_enable  (tx_enable),
    .TxD        (TxD),
    .data       (data),
    .rx_valid   (rx_valid),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [DB-1:0] word;
    logic          stopBit;
    logic [DB-1:0] expData;
    int            expValid;
    int            expFerr;
    int            expCount;
  } rxVec_t;

  rxVec_t vecs [6];

  int assertions;
  int failures;

  // Pulse and run-length monitors, sampled on the falling edge.
  int rxValidCnt;
  int frameErrCnt;
  int parityErrCnt;
  int txdLowCnt;
  int busyRun;
  int idleRun;
  int lastBusyRun;
  int lastGap;

  initial begin
    rxValidCnt   = 0;
    frameErrCnt  = 0;
    parityErrCnt = 0;
    txdLowCnt    = 0;
    busyRun      = 0;
    idleRun      = 0;
    lastBusyRun  = 0;
    lastGap      = 0;
  end

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rxValidCnt++;
    if (frame_err === 1'b1) frameErrCnt++;
    if (parity_err === 1'b1) parityErrCnt++;
    if (TxD === 1'b0) txdLowCnt++;
    if (tx_busy === 1'b1) begin
      if (busyRun == 0) lastGap = idleRun;
      busyRun++;
      idleRun = 0;
    end else begin
      if (busyRun != 0) lastBusyRun = busyRun;
      busyRun = 0;
      idleRun++;
    end
  end

  // Safety net so the run always ends.
  initial begin
    #(60000 * 10);
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic rxVec_t makeVec(input string name, input logic [DB-1:0] word,
                                     input logic stopBit, input logic [DB-1:0] expData,
                                     input int expValid, input int expFerr, input int expCount);
    rxVec_t v;
    v.name     = name;
    v.word     = word;
    v.stopBit  = stopBit;
    v.expData  = expData;
    v.expValid = expValid;
    v.expFerr  = expFerr;
    v.expCount = expCount;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Drives one frame on RxD, bit edges aligned to falling clock edges,
  // followed by one bit time of idle line.
  task automatic sendFrame(input logic [DB-1:0] w, input logic stopBit, input logic flipParity);
    @(negedge clk);
    RxD = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      RxD = w[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    RxD = (^w) ^ flipParity;
    repeat (CPB) @(negedge clk);
`else
    if (flipParity) RxD = 1'b1;
`endif
    RxD = stopBit;
    repeat (CPB) @(negedge clk);
    RxD = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic applyStimulus(input rxVec_t v);
    sendFrame(v.word, v.stopBit, 1'b0);
  endtask

  // Waits (bounded) for a start bit on TxD and decodes the frame at
  // mid-bit points. Returns in the middle of the stop bit.
  task automatic captureTxFrame(output logic [DB-1:0] w, output logic parBit, output logic ok);
    int waited;
    waited = 0;
    ok     = 1'b1;
    w      = '0;
    parBit = 1'b0;
    @(negedge clk);
    while (TxD !== 1'b0 && waited < 4 * FRAME_LEN) begin
      @(negedge clk);
      waited++;
    end
    if (TxD !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (CPB / 2) @(negedge clk);
    if (TxD !== 1'b0) ok = 1'b0;
    for (int i = 0; i < DB; i++) begin
      repeat (CPB) @(negedge clk);
      w[i] = TxD;
    end
`ifdef UART_PARITY_EN
    repeat (CPB) @(negedge clk);
    parBit = TxD;
`endif
    repeat (CPB) @(negedge clk);
    if (TxD !== 1'b1) ok = 1'b0;
  endtask

  logic [DB-1:0] capWord;
  logic          capPar;
  logic          capOk;
  logic [DB-1:0] ovWords [17];
  int            baseValid;
  int            baseFerr;
  int            basePerr;
  int            baseLow;
  int            waited;

  initial begin
    assertions = 0;
    failures   = 0;
    RxD        = 1'b1;
    rx_enable  = 1'b1;
    tx_enable  = 1'b0;
    reset_n    = 1'b0;

    vecs[0] = makeVec("rxA5",     DB'(8'hA5), 1'b1, DB'(8'hA5), 1, 0, 1);
    vecs[1] = makeVec("rx3cBadStop", DB'(8'h3C), 1'b0, DB'(8'hA5), 0, 1, 1);
    vecs[2] = makeVec("rx00",     DB'(8'h00), 1'b1, DB'(8'h00), 1, 0, 2);
    vecs[3] = makeVec("rxFF",     DB'(8'hFF), 1'b1, DB'(8'hFF), 1, 0, 3);
    vecs[4] = makeVec("rx81BadStop", DB'(8'h81), 1'b0, DB'(8'hFF), 0, 1, 3);
    vecs[5] = makeVec("rx5A",     DB'(8'h5A), 1'b1, DB'(8'h5A), 1, 0, 4);

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("resetTxD", TxD, 1);
    checkOutput("resetData", data, 0);
    checkOutput("resetRxValid", rx_valid, 0);
    checkOutput("resetTxBusy", tx_busy, 0);
    checkOutput("resetFifoCount", fifo_count, 0);
    checkOutput("resetOverrun", overrun, 0);
    checkOutput("resetFrameErr", frame_err, 0);
    checkOutput("resetParityErr", parity_err, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Echo of 0xA5 with exact start latency and frame length.
    $display("[TB] echo of a single word");
    tx_enable = 1'b1;
    baseValid = rxValidCnt;
    fork
      sendFrame(DB'(8'hA5), 1'b1, 1'b0);
      begin
        waited = 0;
        while (fifo_count !== 1 && waited < 20 * CPB) begin
          @(negedge clk);
          waited++;
        end
        checkOutput("echoPushSeen", fifo_count, 1);
        @(negedge clk);
        checkOutput("echoTxdIdleEdge1", TxD, 1);
        checkOutput("echoBusyIdleEdge1", tx_busy, 0);
        @(negedge clk);
        checkOutput("echoTxdStartEdge2", TxD, 0);
        checkOutput("echoBusyEdge2", tx_busy, 1);
        captureTxFrame(capWord, capPar, capOk);
        checkOutput("echoFrameOk", capOk, 1);
        checkOutput("echoWord", capWord, DB'(8'hA5));
      end
    join
    repeat (2 * CPB) @(negedge clk);
    checkOutput("echoData", data, DB'(8'hA5));
    checkOutput("echoRxValidPulses", rxValidCnt - baseValid, 1);
    checkOutput("echoFrameLength", lastBusyRun, FRAME_LEN);
    checkOutput("echoFifoDrained", fifo_count, 0);
    tx_enable = 1'b0;

    // Table-driven single-frame receive cases, FIFO accumulating.
    $display("[TB] receive vector table");
    for (int i = 0; i < 6; i++) begin
      baseValid = rxValidCnt;
      baseFerr  = frameErrCnt;
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, "Data"}, data, vecs[i].expData);
      checkOutput({vecs[i].name, "Valid"}, rxValidCnt - baseValid, vecs[i].expValid);
      checkOutput({vecs[i].name, "FrameErr"}, frameErrCnt - baseFerr, vecs[i].expFerr);
      checkOutput({vecs[i].name, "Count"}, fifo_count, vecs[i].expCount);
    end

    // Quarter-bit glitch on the idle line must be rejected.
    $display("[TB] glitch rejection");
    baseValid = rxValidCnt;
    baseFerr  = frameErrCnt;
    @(negedge clk);
    RxD = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    RxD = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checkOutput("glitchNoValid", rxValidCnt - baseValid, 0);
    checkOutput("glitchNoFrameErr", frameErrCnt - baseFerr, 0);
    checkOutput("glitchCount", fifo_count, 4);
    sendFrame(DB'(8'h96), 1'b1, 1'b0);
    checkOutput("afterGlitchData", data, DB'(8'h96));
    checkOutput("afterGlitchCount", fifo_count, 5);

    // Reset while a frame is on TxD; head word is 0xA5, whose bit 1 is 0.
    $display("[TB] reset during transmit");
    tx_enable = 1'b1;
    waited = 0;
    while (tx_busy !== 1'b1 && waited < 10 * CPB) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("midTxBusy", tx_busy, 1);
    repeat (2 * CPB + CPB / 2) @(negedge clk);
    checkOutput("midTxLowBit", TxD, 0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("asyncResetTxD", TxD, 1);
    checkOutput("asyncResetCount", fifo_count, 0);
    checkOutput("asyncResetBusy", tx_busy, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    baseLow = txdLowCnt;
    repeat (3 * FRAME_LEN) @(negedge clk);
    checkOutput("postResetNoTx", txdLowCnt - baseLow, 0);
    checkOutput("postResetBusy", tx_busy, 0);
    checkOutput("postResetData", data, 0);
    tx_enable = 1'b0;

    // Overrun: 17 words into a 16-deep FIFO, then drain in order.
    $display("[TB] overrun and drain");
    baseValid = rxValidCnt;
    for (int i = 0; i < 17; i++) begin
      ovWords[i] = DB'(i * 37 + 11);
      sendFrame(ovWords[i], 1'b1, 1'b0);
      if (i == 15) begin
        checkOutput("fullCount", fifo_count, 16);
        checkOutput("fullNoOverrun", overrun, 0);
      end
    end
    checkOutput("overrunCount", fifo_count, 16);
    checkOutput("overrunSet", overrun, 1);
    checkOutput("overrunData", data, ovWords[16]);
    checkOutput("overrunValidPulses", rxValidCnt - baseValid, 17);
    tx_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      captureTxFrame(capWord, capPar, capOk);
      checkOutput($sformatf("drainOk%0d", i), capOk, 1);
      checkOutput($sformatf("drainWord%0d", i), capWord, ovWords[i]);
    end
    checkOutput("backToBackGap", lastGap, 1);
    repeat (2 * CPB) @(negedge clk);
    checkOutput("drainedCount", fifo_count, 0);
    checkOutput("overrunSticky", overrun, 1);
    rx_enable = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("overrunCleared", overrun, 0);
    rx_enable = 1'b1;
    repeat (2) @(negedge clk);

`ifdef UART_PARITY_EN
    // Wrong parity is dropped; correct parity is echoed with parity bit 0.
    $display("[TB] parity");
    tx_enable = 1'b0;
    baseValid = rxValidCnt;
    basePerr  = parityErrCnt;
    sendFrame(DB'(8'h55), 1'b1, 1'b1);
    checkOutput("badParityPulse", parityErrCnt - basePerr, 1);
    checkOutput("badParityNoValid", rxValidCnt - baseValid, 0);
    checkOutput("badParityCount", fifo_count, 0);
    tx_enable = 1'b1;
    fork
      sendFrame(DB'(8'h55), 1'b1, 1'b0);
      captureTxFrame(capWord, capPar, capOk);
    join
    checkOutput("goodParityFrameOk", capOk, 1);
    checkOutput("goodParityWord", capWord, DB'(8'h55));
    checkOutput("goodParityBit", capPar, 0);
    checkOutput("goodParityNoErr", parityErrCnt - basePerr, 1);
`else
    basePerr = 0;
    checkOutput("parityErrNeverPulses", parityErrCnt - basePerr, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
